// File: rtl/ifmap_buf_writer_pkg.sv
// Shared definitions for the ifmap buffer writer and its address generator peers.
// Holds the writer FSM encoding and the config word field layout, which
// ifmap_radr_gen decodes the same way.
package ifmap_buf_writer_pkg;

    typedef logic [1:0] wr_state_t;

    localparam wr_state_t ST_IDLE = 2'd0;
    localparam wr_state_t ST_FILL = 2'd1;
    localparam wr_state_t ST_FULL = 2'd2;

    // config_data = {IX0, IY0, IC1}; each index is a field slot of
    // BANK_ADDR_WIDTH bits, counted from the LSB.
    localparam int unsigned CFG_NUM_FIELDS = 3;
    localparam int unsigned CFG_IX0_IDX    = 2;
    localparam int unsigned CFG_IY0_IDX    = 1;
    localparam int unsigned CFG_IC1_IDX    = 0;

endpackage

// File: rtl/ifmap_wadr_counter.sv
// Bounded up-counter for the ifmap write address.
// Loads zero on clr, advances on inc and wraps to zero after last_val.
module ifmap_wadr_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] count,
    output logic             at_last
);

    logic [WIDTH-1:0] count_r;

    assign count   = count_r;
    assign at_last = (count_r == last_val);

    // Address counter: clear has priority, wrap happens only at last_val.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc) begin
            if (at_last) begin
                count_r <= {WIDTH{1'b0}};
            end else begin
                count_r <= count_r + WIDTH'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/ifmap_buf_writer.sv
// Write side of the ifmap double buffer.
// Streams one tile of IX0*IY0*IC1 words into the write bank, flags it full and
// swaps banks on switch_banks. Optional macro IFMAP_BUF_WRITER_STALL_CNT_EN adds
// a saturating count of cycles where the stream is valid but not accepted.
module ifmap_buf_writer #(
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH      = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         config_en,
    input  logic [3*BANK_ADDR_WIDTH-1:0] config_data,
    input  logic [DATA_WIDTH-1:0]        ifmap_data,
    input  logic                         ifmap_valid,
    output logic                         ifmap_ready,
    output logic                         buf_wen,
    output logic [BANK_ADDR_WIDTH-1:0]   buf_wadr,
    output logic [DATA_WIDTH-1:0]        buf_wdata,
    output logic                         wbank_sel,
    output logic                         wbank_full,
`ifdef IFMAP_BUF_WRITER_STALL_CNT_EN
    output logic [31:0]                  stall_cnt,
`endif
    input  logic                         switch_banks
);

    import ifmap_buf_writer_pkg::*;

    localparam int PW = CFG_NUM_FIELDS * BANK_ADDR_WIDTH;

    wr_state_t                  state_r;
    wr_state_t                  state_nxt_s;
    logic [BANK_ADDR_WIDTH-1:0] last_adr_r;
    logic [PW-1:0]              tile_words_s;
    logic [PW-1:0]              tile_last_s;
    logic [BANK_ADDR_WIDTH-1:0] cnt_s;
    logic                       at_last_s;
    logic                       accept_s;
    logic                       tile_done_s;
    logic                       bank_toggle_s;

    assign ifmap_ready = (state_r == ST_FILL);
    // A beat that coincides with config_en belongs to the abandoned tile.
    assign accept_s    = ifmap_valid & ifmap_ready & ~config_en;
    assign tile_done_s = accept_s & at_last_s;

    // Full-width product so a tile of exactly 2^BANK_ADDR_WIDTH words still
    // yields last_adr = all ones after truncation.
    assign tile_words_s =
        PW'(config_data[CFG_IX0_IDX*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]) *
        PW'(config_data[CFG_IY0_IDX*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]) *
        PW'(config_data[CFG_IC1_IDX*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]);
    assign tile_last_s  = tile_words_s - PW'(1);

    // Swap on switch_banks once the tile is complete or completing this cycle.
    assign bank_toggle_s = ~config_en & switch_banks &
                           ((state_r == ST_FULL) | tile_done_s);

    ifmap_wadr_counter #(
        .WIDTH (BANK_ADDR_WIDTH)
    ) u_wadr_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (config_en),
        .inc      (accept_s),
        .last_val (last_adr_r),
        .count    (cnt_s),
        .at_last  (at_last_s)
    );

    // Next-state logic; a config load restarts filling from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (config_en) begin
            state_nxt_s = ST_FILL;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_FILL: begin
                    if (tile_done_s && !switch_banks) begin
                        state_nxt_s = ST_FULL;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end
                ST_FULL: begin
                    if (switch_banks) begin
                        state_nxt_s = ST_FILL;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, config and bank status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            last_adr_r <= {BANK_ADDR_WIDTH{1'b0}};
            wbank_sel  <= 1'b0;
            wbank_full <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (config_en) begin
                last_adr_r <= tile_last_s[BANK_ADDR_WIDTH-1:0];
                wbank_full <= 1'b0;
            end else if (bank_toggle_s) begin
                wbank_sel  <= ~wbank_sel;
                wbank_full <= 1'b0;
            end else if (tile_done_s) begin
                wbank_full <= 1'b1;
            end else begin
                wbank_full <= wbank_full;
            end
        end
    end

    // One-cycle write pipeline into the SRAM bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_wen   <= 1'b0;
            buf_wadr  <= {BANK_ADDR_WIDTH{1'b0}};
            buf_wdata <= {DATA_WIDTH{1'b0}};
        end else begin
            buf_wen <= accept_s;
            if (accept_s) begin
                buf_wadr  <= cnt_s;
                buf_wdata <= ifmap_data;
            end else begin
                buf_wadr  <= buf_wadr;
                buf_wdata <= buf_wdata;
            end
        end
    end

`ifdef IFMAP_BUF_WRITER_STALL_CNT_EN
    // Saturating count of valid-but-not-ready cycles since the last config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (config_en) begin
            stall_cnt <= 32'd0;
        end else if (ifmap_valid && !ifmap_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_ifmap_buf_writer.sv
// Self-checking bench for ifmap_buf_writer: directed scenarios plus random
// traffic, compared every cycle against a tile-level reference model.
module tb_ifmap_buf_writer;

    logic        clk;
    logic        rst_n;
    logic        config_en;
    logic [23:0] config_data;
    logic [63:0] ifmap_data;
    logic        ifmap_valid;
    logic        ifmap_ready;
    logic        buf_wen;
    logic [7:0]  buf_wadr;
    logic [63:0] buf_wdata;
    logic        wbank_sel;
    logic        wbank_full;
    logic        switch_banks;
`ifdef IFMAP_BUF_WRITER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: tile size, words already written in this tile, bank.
    bit          m_cfgd;
    bit          m_full;
    bit          m_bank;
    int          m_tile;
    int          m_cnt;
    bit          m_wen;
    int          m_wadr;
    logic [63:0] m_wdata;
    longint      m_stall;

    ifmap_buf_writer #(
        .BANK_ADDR_WIDTH (8),
        .DATA_WIDTH      (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .config_en    (config_en),
        .config_data  (config_data),
        .ifmap_data   (ifmap_data),
        .ifmap_valid  (ifmap_valid),
        .ifmap_ready  (ifmap_ready),
        .buf_wen      (buf_wen),
        .buf_wadr     (buf_wadr),
        .buf_wdata    (buf_wdata),
        .wbank_sel    (wbank_sel),
        .wbank_full   (wbank_full),
`ifdef IFMAP_BUF_WRITER_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .switch_banks (switch_banks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cfgd  = 1'b0;
        m_full  = 1'b0;
        m_bank  = 1'b0;
        m_tile  = 1;
        m_cnt   = 0;
        m_wen   = 1'b0;
        m_wadr  = 0;
        m_wdata = 64'd0;
        m_stall = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {63'd0, ifmap_ready}, 64'd0);
        check_eq({tag, "_wen"},   {63'd0, buf_wen},     64'd0);
        check_eq({tag, "_wadr"},  {56'd0, buf_wadr},    64'd0);
        check_eq({tag, "_wdata"}, buf_wdata,            64'd0);
        check_eq({tag, "_sel"},   {63'd0, wbank_sel},   64'd0);
        check_eq({tag, "_full"},  {63'd0, wbank_full},  64'd0);
`ifdef IFMAP_BUF_WRITER_STALL_CNT_EN
        check_eq({tag, "_stall"}, {32'd0, stall_cnt},   64'd0);
`endif
    endtask

    // One clock cycle: drive, predict, then check the registered outputs.
    task automatic step(input bit cen, input int ix, input int iy, input int ic,
                        input bit vld, input logic [63:0] d, input bit sw);
        bit rdy_exp;
        bit acc;
        @(negedge clk);
        config_en    = cen;
        config_data  = {8'(ix), 8'(iy), 8'(ic)};
        ifmap_valid  = vld;
        ifmap_data   = d;
        switch_banks = sw;
        #1;
        rdy_exp = m_cfgd && !m_full;
        check_eq("ready", {63'd0, ifmap_ready}, {63'd0, rdy_exp});
        acc = vld && rdy_exp;
        if (cen) begin
            m_tile  = ix * iy * ic;
            m_cnt   = 0;
            m_cfgd  = 1'b1;
            m_full  = 1'b0;
            m_wen   = 1'b0;
            m_stall = 0;
        end else begin
            if (vld && !rdy_exp && m_stall != 64'hFFFF_FFFF) m_stall++;
            m_wen = acc;
            if (acc) begin
                m_wadr  = m_cnt;
                m_wdata = d;
                if (m_cnt == m_tile - 1) begin
                    m_cnt = 0;
                    if (sw) m_bank = !m_bank;
                    else    m_full = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else if (m_full && sw) begin
                m_bank = !m_bank;
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("wen", {63'd0, buf_wen}, {63'd0, m_wen});
        if (m_wen) begin
            check_eq("wadr",  {56'd0, buf_wadr}, 64'(m_wadr));
            check_eq("wdata", buf_wdata, m_wdata);
        end
        check_eq("sel",  {63'd0, wbank_sel},  {63'd0, m_bank});
        check_eq("full", {63'd0, wbank_full}, {63'd0, m_full});
`ifdef IFMAP_BUF_WRITER_STALL_CNT_EN
        check_eq("stall", {32'd0, stall_cnt}, 64'(m_stall));
`endif
    endtask

    task automatic idle_cycle();
        step(1'b0, 0, 0, 0, 1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        int ix, iy, ic;
        bit vld, sw, cen;
        rst_n        = 1'b0;
        config_en    = 1'b0;
        config_data  = 24'd0;
        ifmap_data   = 64'd0;
        ifmap_valid  = 1'b0;
        switch_banks = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Full 5x5x2 tile with valid held high, then stall in FULL.
        step(1'b1, 5, 5, 2, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 5, 5, 2, 1'b1, 64'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 5, 5, 2, 1'b1, 64'hDEAD, 1'b0);
`ifdef IFMAP_BUF_WRITER_STALL_CNT_EN
        check_eq("stall10", {32'd0, stall_cnt}, 64'd10);
`endif
        // Bank swap, then alternating valid.
        step(1'b0, 5, 5, 2, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 5, 5, 2, 1'(~i & 1), 64'(100 + i), 1'b0);

        // Last beat together with switch_banks.
        step(1'b1, 5, 5, 2, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 49; i++) step(1'b0, 5, 5, 2, 1'b1, 64'(200 + i), 1'b0);
        step(1'b0, 5, 5, 2, 1'b1, 64'd249, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 5, 5, 2, 1'b1, 64'(300 + i), 1'b0);

        // Reconfigure mid-fill to 3x3x1.
        step(1'b1, 5, 5, 2, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 5, 5, 2, 1'b1, 64'(400 + i), 1'b0);
        step(1'b1, 3, 3, 1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 3, 3, 1, 1'b1, 64'(500 + i), 1'b0);

        // Largest tile: 16x16x1 = 256 words.
        step(1'b1, 16, 16, 1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 258; i++) step(1'b0, 16, 16, 1, 1'b1, 64'(600 + i), 1'b0);
        step(1'b0, 16, 16, 1, 1'b0, 64'd0, 1'b1);

        // Asynchronous reset mid-fill.
        step(1'b1, 4, 4, 2, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 4, 4, 2, 1'b1, 64'(900 + i), 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 4, 4, 2, 1'b1, 64'(950 + i), 1'b1);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            cen = ($urandom_range(0, 99) < 2) || !m_cfgd;
            ix  = $urandom_range(1, 8);
            iy  = $urandom_range(1, 8);
            ic  = $urandom_range(1, 4);
            vld = cen ? 1'b0 : ($urandom_range(0, 99) < 75);
            sw  = ($urandom_range(0, 99) < 12);
            step(cen, ix, iy, ic, vld, {$urandom, $urandom}, sw);
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
